// File: rtl/speed_converter.sv
// speed_converter: parses an ASCII knots field one character per cycle, scales it to
// mph / km/h / knots (x100), saturates to DIGITS decimal digits and serially converts to BCD.
module speed_converter #(
  parameter int NCHAR  = 6,
  parameter int DIGITS = 5,
  parameter int OUT_W  = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NCHAR-1:0]  chars,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    value_x100,
  output logic [4*DIGITS-1:0] bcd,
  output logic                err,
  output logic                ovf
);
  // 10^n < 16^n, x100 < 2^7 and x1852 < 2^11, so none of these widths can wrap
  localparam int IW   = 4*NCHAR;
  localparam int KW   = IW + 7;
  localparam int PW   = KW + 11;
  localparam int CMAX = (NCHAR > OUT_W) ? NCHAR : OUT_W;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [PW-1:0] MAXV = PW'(10**DIGITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PARSE, S_SCALE, S_BCD, S_DONE} state_t;
  state_t r_state, w_next;

  logic [8*NCHAR-1:0]  r_chars;
  logic [1:0]          r_mode;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_int;
  logic [6:0]          r_frac;
  logic [1:0]          r_nfrac;
  logic                r_dot, r_term, r_any, r_perr;
  logic [OUT_W-1:0]    r_bin, r_val;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_err_p, r_ovf_p;

  logic [7:0]          w_c;
  logic                w_dig, w_dotc, w_termc;
  logic                w_last_parse, w_last_bcd;
  logic [6:0]          w_f100;
  logic [KW-1:0]       w_k;
  logic [PW-1:0]       w_prod;
  logic                w_err, w_sat;
  logic [OUT_W-1:0]    w_res;
  logic [4*DIGITS-1:0] w_adj, w_bcd_nxt;

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign w_last_parse = (r_cnt == CW'(NCHAR-1));
  assign w_last_bcd   = (r_cnt == CW'(OUT_W-1));

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)     w_next = S_PARSE;
      S_PARSE: if (w_last_parse) w_next = S_SCALE;
      S_SCALE:                   w_next = S_BCD;
      S_BCD:   if (w_last_bcd)   w_next = S_DONE;
      S_DONE:  if (out_ready)    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  assign w_c     = r_chars[7:0];
  assign w_dig   = (w_c >= 8'h30) && (w_c <= 8'h39);
  assign w_dotc  = (w_c == 8'h2E);
  assign w_termc = (w_c == 8'h2C) || (w_c == 8'h20) || (w_c == 8'h2A) || (w_c == 8'h00);

  // Fraction is normalised to hundredths before the integer part is merged in
  always_comb begin
    case (r_nfrac)
      2'd0:    w_f100 = 7'd0;
      2'd1:    w_f100 = r_frac * 7'd10;
      default: w_f100 = r_frac;
    endcase
    w_k = KW'(r_int) * KW'(100) + KW'(w_f100);
    case (r_mode)
      2'd0:    w_prod = (PW'(w_k) * PW'(1151)) / PW'(1000);
      2'd1:    w_prod = (PW'(w_k) * PW'(1852)) / PW'(1000);
      default: w_prod = PW'(w_k);
    endcase
  end

  assign w_err = r_perr | ~r_any | (r_mode == 2'd3);
  assign w_sat = (w_prod > MAXV);
  assign w_res = w_err ? '0 : (w_sat ? OUT_W'(MAXV) : OUT_W'(w_prod));

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++)
      if (w_adj[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = w_adj[4*i +: 4] + 4'd3;
    w_bcd_nxt = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[OUT_W-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chars <= '0; r_mode <= '0; r_cnt <= '0;
      r_int <= '0; r_frac <= '0; r_nfrac <= '0;
      r_dot <= 1'b0; r_term <= 1'b0; r_any <= 1'b0; r_perr <= 1'b0;
      r_bin <= '0; r_val <= '0; r_bcd <= '0; r_err_p <= 1'b0; r_ovf_p <= 1'b0;
      value_x100 <= '0; bcd <= '0; err <= 1'b0; ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_chars <= chars; r_mode <= mode; r_cnt <= '0;
          r_int <= '0; r_frac <= '0; r_nfrac <= '0;
          r_dot <= 1'b0; r_term <= 1'b0; r_any <= 1'b0; r_perr <= 1'b0;
        end
        S_PARSE: begin
          r_chars <= r_chars >> 8;
          r_cnt   <= r_cnt + CW'(1);
          if (!r_term) begin
            if (w_dig) begin
              r_any <= 1'b1;
              if (!r_dot) r_int <= r_int * IW'(10) + IW'(w_c[3:0]);
              else if (r_nfrac != 2'd2) begin
                r_frac  <= r_frac * 7'd10 + 7'(w_c[3:0]);
                r_nfrac <= r_nfrac + 2'd1;
              end
            end else if (w_dotc) begin
              if (r_dot) r_perr <= 1'b1;
              r_dot <= 1'b1;
            end else if (w_termc) r_term <= 1'b1;
            else r_perr <= 1'b1;
          end
        end
        S_SCALE: begin
          r_cnt   <= '0;
          r_bcd   <= '0;
          r_bin   <= w_res;
          r_val   <= w_res;
          r_err_p <= w_err;
          r_ovf_p <= ~w_err & w_sat;
        end
        S_BCD: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last_bcd) begin
            value_x100 <= r_val;
            bcd        <= w_bcd_nxt;
            err        <= r_err_p;
            ovf        <= r_ovf_p;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_speed_converter.sv
// Bench for speed_converter: fixed vector table, randomized fields against a string-level
// reference model, plus backpressure, asynchronous reset and back-to-back stream sequences.
module tb_speed_converter;
  localparam int NCHAR = 6, DIGITS = 5, OUT_W = 17;
  localparam int LAT = NCHAR + OUT_W + 1;
  localparam int LIM = 200;
  localparam longint MAXV = 99999;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, err, ovf;
  logic [8*NCHAR-1:0]  chars;
  logic [1:0]          mode;
  logic [OUT_W-1:0]    value_x100;
  logic [4*DIGITS-1:0] bcd;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  speed_converter #(.NCHAR(NCHAR), .DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .chars(chars),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .value_x100(value_x100),
    .bcd(bcd), .err(err), .ovf(ovf));

  typedef struct {
    logic [8*NCHAR-1:0] f;
    logic [1:0]         m;
    longint             v;
    bit                 e;
    bit                 o;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8*NCHAR-1:0] pack(input string s);
    logic [8*NCHAR-1:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < NCHAR; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
    logic [4*DIGITS-1:0] r;
    longint t;
    r = '0; t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: cut the field at the first terminator, then read it as a decimal number
  function automatic void model(input logic [8*NCHAR-1:0] f, input int md,
                                output longint val, output bit e, output bit o);
    logic [7:0] c;
    int n, dots, ndig, nf;
    bit bad;
    longint ip, fr, k, s;
    n = NCHAR;
    for (int i = NCHAR-1; i >= 0; i--) begin
      c = f[8*i +: 8];
      if (c == 8'h2C || c == 8'h20 || c == 8'h2A || c == 8'h00) n = i;
    end
    dots = 0; ndig = 0; nf = 0; bad = 0; ip = 0; fr = 0;
    for (int i = 0; i < n; i++) begin
      c = f[8*i +: 8];
      if (c == 8'h2E) dots++;
      else if (c >= 8'h30 && c <= 8'h39) begin
        ndig++;
        if (dots == 0) ip = ip * 10 + longint'(c - 8'h30);
        else if (nf < 2) begin fr = fr * 10 + longint'(c - 8'h30); nf++; end
      end else bad = 1;
    end
    e = bad || dots > 1 || ndig == 0 || md == 3;
    k = ip * 100 + (nf == 0 ? 0 : (nf == 1 ? fr * 10 : fr));
    s = (md == 0) ? k * 1151 / 1000 : ((md == 1) ? k * 1852 / 1000 : k);
    if (e) begin val = 0; o = 0; end
    else if (s > MAXV) begin val = MAXV; o = 1; end
    else begin val = s; o = 0; end
  endfunction

  function automatic logic [8*NCHAR-1:0] rand_field();
    logic [8*NCHAR-1:0] v;
    int r;
    for (int i = 0; i < NCHAR; i++) begin
      r = $urandom_range(0, 21);
      case (r)
        10, 11:  v[8*i +: 8] = 8'h2E;
        12:      v[8*i +: 8] = 8'h2C;
        13:      v[8*i +: 8] = 8'h20;
        14:      v[8*i +: 8] = 8'h2A;
        15:      v[8*i +: 8] = 8'h00;
        16:      v[8*i +: 8] = 8'h78;
        default: v[8*i +: 8] = 8'h30 + 8'($urandom_range(0, 9));
      endcase
    end
    return v;
  endfunction

  task automatic add(input string s, input int m, input longint v, input bit e, input bit o);
    vec_t t;
    t.f = pack(s); t.m = 2'(m); t.v = v; t.e = e; t.o = o;
    tbl.push_back(t);
  endtask

  task automatic send(input logic [8*NCHAR-1:0] f, input logic [1:0] m);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; chars = f; mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chars = 48'({$urandom(), $urandom()});
    mode = 2'($urandom());
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < LIM) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pop(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_ovalid_low"}, out_valid, 0);
    check({name, "_iready_high"}, in_ready, 1);
  endtask

  task automatic run_chk(input string name, input logic [8*NCHAR-1:0] f, input logic [1:0] m,
                         input longint v, input bit e, input bit o);
    int n;
    send(f, m);
    wait_out(n);
    check({name, "_latency"}, n, LAT);
    check({name, "_value"}, value_x100, v);
    check({name, "_bcd"}, bcd, to_bcd(v));
    check({name, "_err"}, err, e);
    check({name, "_ovf"}, ovf, o);
    pop(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    longint mv;
    bit me, mo;
    logic [8*NCHAR-1:0] rf;
    logic [1:0] rm;
    longint q[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; chars = '0; mode = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_value", value_x100, 0);
    check("rst_bcd", bcd, 0);
    check("rst_err", err, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;

    add("12.5,,", 0, 1438, 0, 0);
    add("3.456 ", 1, 638, 0, 0);
    add("7*9999", 2, 700, 0, 0);
    add("999.99", 0, 99999, 0, 1);
    add("1.2.3,", 0, 0, 1, 0);
    add("10.00,", 3, 0, 1, 0);
    add("0.5   ", 2, 50, 0, 0);
    add("1a2,,,", 2, 0, 1, 0);
    add(",12345", 2, 0, 1, 0);
    add("999999", 1, 99999, 0, 1);
    add(".7,,,,", 2, 70, 0, 0);
    add("86.8  ", 0, 9990, 0, 0);
    add("45    ", 1, 8334, 0, 0);
    add("999.99", 2, 99999, 0, 0);
    add("1000.0", 2, 99999, 0, 1);
    foreach (tbl[i])
      run_chk($sformatf("vec%0d", i), tbl[i].f, tbl[i].m, tbl[i].v, tbl[i].e, tbl[i].o);

    for (int i = 0; i < 100; i++) begin
      rf = rand_field();
      rm = 2'($urandom_range(0, 3));
      model(rf, int'(rm), mv, me, mo);
      run_chk($sformatf("rnd%0d", i), rf, rm, mv, me, mo);
    end

    // backpressure: result held, no accept while out_valid
    send(pack("12.5,,"), 2'd0);
    wait_out(n);
    check("bp_latency", n, LAT);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      chars = 48'({$urandom(), $urandom()});
      @(posedge clk); #1;
      check("bp_ovalid", out_valid, 1);
      check("bp_iready", in_ready, 0);
      check("bp_value", value_x100, 1438);
      check("bp_bcd", bcd, 20'h01438);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_rel_ovalid", out_valid, 0);
    check("bp_rel_iready", in_ready, 1);
    chars = pack("2.5,,,"); mode = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_accept", in_ready, 0);
    wait_out(n);
    check("bp_new_latency", n, LAT);
    check("bp_new_value", value_x100, 250);
    pop("bp_new");

    // asynchronous reset in the middle of BCD conversion
    send(pack("45    "), 2'd1);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ovalid", out_valid, 0);
    check("arst_iready", in_ready, 1);
    check("arst_value", value_x100, 0);
    check("arst_bcd", bcd, 0);
    #2 rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("arst_no_result", cnt, 0);
    run_chk("arst_next", pack("45    "), 2'd1, 8334, 0, 0);

    // back-to-back stream with out_ready held high
    out_ready = 1'b1;
    fork
      begin
        logic [8*NCHAR-1:0] sf[3];
        logic [1:0] sm[3];
        int k;
        sf[0] = pack("1.5,,,"); sm[0] = 2'd0;
        sf[1] = pack("22    "); sm[1] = 2'd1;
        sf[2] = pack("3.33**"); sm[2] = 2'd2;
        for (int i = 0; i < 3; i++) begin
          chars = sf[i]; mode = sm[i]; in_valid = 1'b1;
          k = 0;
          do begin @(negedge clk); k++; end while (!in_ready && k < LIM);
          if (k >= LIM) check("stream_accept_timeout", 0, 1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 120; c++) begin
          @(negedge clk);
          if (out_valid) q.push_back(longint'(value_x100));
        end
      end
    join
    out_ready = 1'b0;
    check("stream_count", q.size(), 3);
    check("stream_r0", q.size() > 0 ? q[0] : -1, 172);
    check("stream_r1", q.size() > 1 ? q[1] : -1, 4074);
    check("stream_r2", q.size() > 2 ? q[2] : -1, 333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/speed_converter.md
SPEED_CONVERTER -- requirements
Module: speed_converter

Interface
REQ-001 Parameter NCHAR, default 6: number of ASCII input characters per speed field.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits.
REQ-003 Parameter OUT_W, default 17: width of the binary x100 result; SHALL be at least ceil(log2(10^DIGITS)).
REQ-004 clk  input  1  single clock, all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a speed field is presented on chars/mode.
REQ-007 in_ready  output  1  block can accept a field; high only in IDLE.
REQ-008 chars  input  8*NCHAR  ASCII field; char 0 (first, most significant) at bits [7:0], char i at [8i+7:8i].
REQ-009 mode  input  2  0 = knots->mph, 1 = knots->km/h, 2 = knots passthrough, 3 = reserved.
REQ-010 out_valid  output  1  result available; held until accepted.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 value_x100  output  OUT_W  converted speed x100, binary.
REQ-013 bcd  output  4*DIGITS  converted speed x100 as BCD; most significant digit in the top nibble.
REQ-014 err  output  1  field was malformed or mode was reserved.
REQ-015 ovf  output  1  result saturated.

Function
REQ-016 Input handshake: a field SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; chars and mode SHALL be latched at that edge and may change afterwards.
REQ-017 FSM states: IDLE -> PARSE -> SCALE -> BCD -> DONE -> IDLE; no other states.
REQ-018 PARSE SHALL examine exactly one character per cycle, char 0 first, for exactly NCHAR cycles regardless of content.
REQ-019 Parsing: digits '0'-'9' accumulate; one '.' marks the start of the fraction; the first terminator (',', ' ', '*', 0x00) ends the field; all characters after a terminator are ignored.
REQ-020 Fraction: the first two fraction digits are kept; further fraction digits are truncated; with 0 or 1 fraction digits the value is scaled x100 or x10 so that the result is knots x100.
REQ-021 err SHALL be set for: any other character before a terminator, a second '.', no digit before the terminator/end, or mode=3.
REQ-022 SCALE (1 cycle): mode 0 -> floor(k*1151/1000); mode 1 -> floor(k*1852/1000); mode 2 -> k; k = knots x100.
REQ-023 Internal arithmetic SHALL NOT wrap for any NCHAR-character input.
REQ-024 If the scaled result exceeds 10^DIGITS-1, value_x100 SHALL saturate to 10^DIGITS-1 and ovf=1.
REQ-025 On err, value_x100=0, bcd=0 and ovf=0; the result still follows the normal latency.
REQ-026 BCD state SHALL perform shift-add-3 binary-to-BCD conversion, one bit per cycle, for exactly OUT_W cycles.
REQ-027 Latency: for a field accepted at edge E0, out_valid SHALL rise at edge E0+NCHAR+OUT_W+1.
REQ-028 value_x100, bcd, err and ovf SHALL update only when out_valid rises, and SHALL stay stable while out_valid=1.
REQ-029 Output handshake: an edge with out_valid=1 and out_ready=1 completes the transfer; out_valid=0 and in_ready=1 from the next cycle.
REQ-030 A new field SHALL NOT be accepted in the same edge as output acceptance.
REQ-031 in_valid is ignored outside IDLE; changes to chars or mode outside IDLE SHALL NOT affect the result in progress.

Reset
REQ-032 On rst=1, the FSM SHALL go to IDLE immediately, independent of clk, and SHALL drive in_ready=1, out_valid=0, value_x100=0, bcd=0, err=0, ovf=0.
REQ-033 Reset in any state SHALL discard the field in progress with no partial output; the first edge after rst falls may accept a field.

Verification (NCHAR=6, DIGITS=5, OUT_W=17)
REQ-034 "12.5,," mode 0 -> out_valid at E0+24; value_x100=1438, bcd=0x01438, err=0, ovf=0.
REQ-035 "3.456 " mode 1 -> value_x100=638 (0.006 truncated), bcd=0x00638; "7*9999" mode 2 -> value_x100=700.
REQ-036 "999.99" mode 0 -> value_x100=99999, bcd=0x99999, ovf=1, err=0; "1.2.3," -> err=1, value_x100=0, bcd=0, latency unchanged.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles after out_valid; toggle chars and keep in_valid=1 -> outputs stable, in_ready=0, no accept; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle, then a new accept.
REQ-038 Assert rst mid-BCD (asynchronously, between edges) -> out_valid=0 and in_ready=1 immediately; no result for the aborted field; the next field converts correctly.
REQ-039 Mode 3 with "10.00," -> err=1, value_x100=0; a back-to-back stream of 3 fields with out_ready=1 -> exactly 3 results, in order.
